// File: rtl/p_beid_interconnect_f0_ahb_mtx_cfg_default_slave_pkg.sv
// p_beid_interconnect_f0_ahb_mtx_cfg_default_slave_pkg: shared AHB encodings and default-slave FSM states
package p_beid_interconnect_f0_ahb_mtx_cfg_default_slave_pkg;
  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ  = 2'b11;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2,
    ST_OK
  } state_e;
endpackage

// File: rtl/p_beid_interconnect_f0_ahb_mtx_fault_rec.sv
// p_beid_interconnect_f0_ahb_mtx_fault_rec: first-access capture with saturating access count
module p_beid_interconnect_f0_ahb_mtx_fault_rec
  import p_beid_interconnect_f0_ahb_mtx_cfg_default_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  accept,
  input  logic                  clr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  write,
  output logic                  valid_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  write_o,
  output logic [CNT_WIDTH-1:0]  cnt_o
);
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  capture;
  // a clear coinciding with an accept still captures the new access and counts it as the first
  always_comb begin
    capture = accept & (~valid_q | clr);
    valid_d = accept | (valid_q & ~clr);
    addr_d  = capture ? addr : addr_q;
    write_d = capture ? write : write_q;
    cnt_d   = clr ? (accept ? CNT_WIDTH'(1) : '0)
            : (accept && !(&cnt_q)) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
  end
  // record registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      write_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      cnt_q   <= cnt_d;
    end
  end
  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign write_o = write_q;
  assign cnt_o   = cnt_q;
endmodule

// File: rtl/p_beid_interconnect_f0_ahb_mtx_cfg_default_slave.sv
// p_beid_interconnect_f0_ahb_mtx_cfg_default_slave: AHB default slave with wait states, ERROR/OKAY mode and fault record
module p_beid_interconnect_f0_ahb_mtx_cfg_default_slave
  import p_beid_interconnect_f0_ahb_mtx_cfg_default_slave_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_STATES = 0,
  parameter int RESP_MODE   = 1,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  output logic                  HREADYOUT,
  output logic [1:0]            HRESP,
  output logic [31:0]           HRDATA,
  input  logic                  FAULT_CLR,
  output logic                  FAULT_VALID,
  output logic [ADDR_WIDTH-1:0] FAULT_ADDR,
  output logic                  FAULT_WRITE,
  output logic [CNT_WIDTH-1:0]  FAULT_CNT
);
  localparam state_e ST_DONE = (RESP_MODE != 0) ? ST_ERR1 : ST_OK;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  if (WAIT_STATES > 15 || WAIT_STATES < 0) begin : g_cfg_err
    $fatal(1, "WAIT_STATES=%0d outside legal range 0..15", WAIT_STATES);
  end

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       hreadyout_q, hreadyout_d;
  logic [1:0] hresp_q, hresp_d;
  logic       accept;

  assign accept = HSEL & HREADY & HTRANS[1] & hreadyout_q;

  // next state, wait counter and the registered response it implies
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_DONE;
        else cnt_d = cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        if (accept) begin
          state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_DONE;
          cnt_d   = WAIT_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
    hreadyout_d = !(state_d inside {ST_WAIT, ST_ERR1});
    hresp_d     = (state_d inside {ST_ERR1, ST_ERR2}) ? HRESP_ERROR : HRESP_OKAY;
  end

  // FSM and response registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = 32'd0;

  p_beid_interconnect_f0_ahb_mtx_fault_rec #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_fault_rec (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .accept (accept),
    .clr    (FAULT_CLR),
    .addr   (HADDR),
    .write  (HWRITE),
    .valid_o(FAULT_VALID),
    .addr_o (FAULT_ADDR),
    .write_o(FAULT_WRITE),
    .cnt_o  (FAULT_CNT)
  );
endmodule

// File: tb/tb_p_beid_interconnect_f0_ahb_mtx_cfg_default_slave.sv
// tb_p_beid_interconnect_f0_ahb_mtx_cfg_default_slave: four configurations checked against a response-sequence model
module tb_p_beid_interconnect_f0_ahb_mtx_cfg_default_slave;
  function automatic int ws_of(int i);
    return (i == 1) ? 3 : (i == 2) ? 2 : 0;
  endfunction
  function automatic int md_of(int i);
    return (i < 2) ? 1 : 0;
  endfunction
  function automatic int cw_of(int i);
    return (i == 3) ? 2 : 8;
  endfunction

  logic        HCLK, HRESETn, HSEL, HREADY, HWRITE, FAULT_CLR;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR;
  logic        rdy [4];
  logic [1:0]  resp [4];
  logic [31:0] rdata [4];
  logic        fv [4];
  logic [31:0] fa [4];
  logic        fw [4];
  logic [7:0]  fc [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int CW = cw_of(g);
    logic [CW-1:0] c;
    p_beid_interconnect_f0_ahb_mtx_cfg_default_slave #(
      .ADDR_WIDTH (32),
      .WAIT_STATES(ws_of(g)),
      .RESP_MODE  (md_of(g)),
      .CNT_WIDTH  (CW)
    ) u_dut (
      .HCLK       (HCLK),
      .HRESETn    (HRESETn),
      .HSEL       (HSEL),
      .HTRANS     (HTRANS),
      .HREADY     (HREADY),
      .HADDR      (HADDR),
      .HWRITE     (HWRITE),
      .HREADYOUT  (rdy[g]),
      .HRESP      (resp[g]),
      .HRDATA     (rdata[g]),
      .FAULT_CLR  (FAULT_CLR),
      .FAULT_VALID(fv[g]),
      .FAULT_ADDR (fa[g]),
      .FAULT_WRITE(fw[g]),
      .FAULT_CNT  (c)
    );
    assign fc[g] = 8'(c);
  end

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int errors = 0;
  int checks = 0;

  // model: each accepted transfer queues the {ready,resp} cycles it will show
  logic [2:0]  rq [4][$];
  logic [2:0]  cur [4];
  bit          m_fv [4];
  logic [31:0] m_fa [4];
  bit          m_fw [4];
  int          m_fc [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      rq[i].delete();
      cur[i] = 3'b100;
      m_fv[i] = 1'b0;
      m_fa[i] = '0;
      m_fw[i] = 1'b0;
      m_fc[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 4; i++) begin
      bit acc;
      int mx;
      mx  = (1 << cw_of(i)) - 1;
      acc = HSEL && HREADY && HTRANS[1] && cur[i][2];
      if (acc) begin
        if (!m_fv[i] || FAULT_CLR) begin
          m_fa[i] = HADDR;
          m_fw[i] = HWRITE;
        end
        m_fv[i] = 1'b1;
        m_fc[i] = FAULT_CLR ? 1 : (m_fc[i] < mx ? m_fc[i] + 1 : m_fc[i]);
        for (int k = 0; k < ws_of(i); k++) rq[i].push_back(3'b000);
        if (md_of(i) == 1) begin
          rq[i].push_back(3'b001);
          rq[i].push_back(3'b101);
        end else begin
          rq[i].push_back(3'b100);
        end
      end else if (FAULT_CLR) begin
        m_fv[i] = 1'b0;
        m_fc[i] = 0;
      end
      cur[i] = (rq[i].size() > 0) ? rq[i].pop_front() : 3'b100;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("d%0d_hreadyout", i), 32'(rdy[i]), 32'(cur[i][2]));
      chk($sformatf("d%0d_hresp", i), 32'(resp[i]), 32'(cur[i][1:0]));
      chk($sformatf("d%0d_hrdata", i), rdata[i], 32'd0);
      chk($sformatf("d%0d_fault_valid", i), 32'(fv[i]), 32'(m_fv[i]));
      chk($sformatf("d%0d_fault_addr", i), fa[i], m_fa[i]);
      chk($sformatf("d%0d_fault_write", i), 32'(fw[i]), 32'(m_fw[i]));
      chk($sformatf("d%0d_fault_cnt", i), 32'(fc[i]), 32'(m_fc[i]));
    end
  endtask

  task automatic drv(input logic sel, input logic [1:0] tr, input logic hr,
                     input logic [31:0] a, input logic wr, input logic clr);
    HSEL = sel;
    HTRANS = tr;
    HREADY = hr;
    HADDR = a;
    HWRITE = wr;
    FAULT_CLR = clr;
  endtask

  task automatic step();
    @(posedge HCLK);
    if (HRESETn) model_edge();
    @(negedge HCLK);
    check_all();
  endtask

  initial begin
    HRESETn = 1'b0;
    drv(0, 2'b00, 1, 32'h0, 0, 0);
    model_reset();
    repeat (2) @(negedge HCLK);
    check_all();
    HRESETn = 1'b1;
    drv(1, 2'b10, 1, 32'h4000_0010, 1, 0);
    step();
    chk("m1ws0_err1_rdy", 32'(rdy[0]), 32'd0);
    chk("m1ws0_err1_resp", 32'(resp[0]), 32'd1);
    chk("m1ws0_addr", fa[0], 32'h4000_0010);
    chk("m1ws0_write", 32'(fw[0]), 32'd1);
    chk("m1ws0_cnt", 32'(fc[0]), 32'd1);
    drv(0, 2'b00, 1, 32'h0, 0, 0);
    step();
    chk("m1ws0_err2_rdy", 32'(rdy[0]), 32'd1);
    chk("m1ws0_err2_resp", 32'(resp[0]), 32'd1);
    chk("m1ws3_wait_rdy", 32'(rdy[1]), 32'd0);
    step();
    chk("m0ws2_ok_rdy", 32'(rdy[2]), 32'd1);
    chk("m0ws2_ok_resp", 32'(resp[2]), 32'd0);
    chk("m0ws2_ok_rdata", rdata[2], 32'd0);
    step();
    chk("m1ws3_err1_rdy", 32'(rdy[1]), 32'd0);
    chk("m1ws3_err1_resp", 32'(resp[1]), 32'd1);
    step();
    chk("m1ws3_err2_rdy", 32'(rdy[1]), 32'd1);
    chk("m1ws3_err2_resp", 32'(resp[1]), 32'd1);
    drv(1, 2'b10, 1, 32'h0000_0050, 0, 0);
    repeat (3) step();
    chk("b2b_err1_rdy", 32'(rdy[0]), 32'd0);
    chk("b2b_err1_resp", 32'(resp[0]), 32'd1);
    chk("b2b_addr_kept", fa[0], 32'h4000_0010);
    chk("b2b_cnt", 32'(fc[0]), 32'd3);
    drv(0, 2'b00, 1, 32'h0, 0, 0);
    repeat (8) step();
    drv(1, 2'b10, 1, 32'h0000_0060, 1, 0);
    step();
    drv(0, 2'b00, 1, 32'h0, 0, 0);
    repeat (3) step();
    chk("pre_rst_err1_rdy", 32'(rdy[1]), 32'd0);
    chk("pre_rst_err1_resp", 32'(resp[1]), 32'd1);
    #2 HRESETn = 1'b0;
    #1;
    chk("rst_rdy", 32'(rdy[1]), 32'd1);
    chk("rst_resp", 32'(resp[1]), 32'd0);
    chk("rst_cnt", 32'(fc[1]), 32'd0);
    chk("rst_valid", 32'(fv[1]), 32'd0);
    model_reset();
    @(negedge HCLK);
    check_all();
    HRESETn = 1'b1;
    drv(1, 2'b10, 1, 32'h0000_0070, 0, 0);
    repeat (5) step();
    chk("sat_cnt", 32'(fc[3]), 32'd3);
    drv(1, 2'b11, 1, 32'h0000_0080, 1, 1);
    step();
    chk("clr_acc_cnt", 32'(fc[3]), 32'd1);
    chk("clr_acc_valid", 32'(fv[3]), 32'd1);
    chk("clr_acc_addr", fa[3], 32'h0000_0080);
    chk("clr_acc_write", 32'(fw[3]), 32'd1);
    drv(0, 2'b00, 1, 32'h0, 0, 1);
    step();
    chk("clr_valid", 32'(fv[3]), 32'd0);
    chk("clr_cnt", 32'(fc[3]), 32'd0);
    chk("clr_addr_hold", fa[3], 32'h0000_0080);
    drv(0, 2'b00, 1, 32'h0, 0, 0);
    repeat (6) step();
    drv(1, 2'b01, 1, 32'h0000_0090, 1, 0);
    step();
    chk("busy_rdy", 32'(rdy[2]), 32'd1);
    chk("busy_resp", 32'(resp[2]), 32'd0);
    drv(1, 2'b00, 1, 32'h0000_00a0, 0, 0);
    step();
    chk("idle_rdy", 32'(rdy[2]), 32'd1);
    chk("idle_cnt", 32'(fc[2]), 32'(m_fc[2]));
    repeat (600) begin
      drv(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), ($urandom_range(0, 7) != 0),
          $urandom(), 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
